// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, inst} feeding registered decode-stage outputs.
// Optional feature macro IFQ_BYPASS_EN: an empty queue forwards the fetch entry straight into decode.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               stall,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [INST_W-1:0]        if_inst,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [INST_W-1:0]        id_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_id_valid;
    logic [ADDR_W-1:0] r_id_pc;
    logic [INST_W-1:0] r_id_inst;

    logic w_full;
    logic w_empty;
    logic w_advance;
    logic w_push;
    logic w_pop;
    logic w_unused_stall;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_advance = ~stall[2];
    assign w_pop     = w_advance & ~w_empty & ~flush;

    // Only the decode-stage stall bit matters to this block.
    assign w_unused_stall = ^{stall[5:3], stall[1:0]};

`ifdef IFQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass = w_empty & w_advance & if_valid & ~flush;
    assign w_push   = if_valid & ~w_full & ~flush & ~w_bypass;
`else
    assign w_push   = if_valid & ~w_full & ~flush;
`endif

    assign if_ready = ~w_full;
    assign id_valid = r_id_valid;
    assign id_pc    = r_id_pc;
    assign id_inst  = r_id_inst;
    assign count    = r_count;

    // Storage is deliberately left unreset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= if_pc;
            r_mem_inst[r_wr_ptr] <= if_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
        end else if (w_advance) begin
            if (!w_empty) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= r_mem_pc[r_rd_ptr];
                r_id_inst  <= r_mem_inst[r_rd_ptr];
            end
`ifdef IFQ_BYPASS_EN
            else if (w_bypass) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= if_pc;
                r_id_inst  <= if_inst;
            end
`endif
            else begin
                r_id_valid <= 1'b0;
                r_id_pc    <= '0;
                r_id_inst  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios then random traffic, checked against a queue-based model.
module tb_if_id_queue;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        stall;
    logic              flush;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [$clog2(DEPTH):0] count;

    if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
        .id_inst(id_inst), .count(count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0]       m_q[$];
    logic              m_v    = 1'b0;
    logic [ADDR_W-1:0] m_pc   = '0;
    logic [INST_W-1:0] m_inst = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_update();
        logic [63:0] e;
        bit rdy;
        bit pushing;
        if (rst || flush) begin
            m_q.delete();
            m_v = 1'b0; m_pc = '0; m_inst = '0;
        end else begin
            rdy     = m_q.size() < DEPTH;
            pushing = if_valid && rdy;
            if (!stall[2]) begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    m_v = 1'b1; m_pc = e[63:32]; m_inst = e[31:0];
                end
`ifdef IFQ_BYPASS_EN
                else if (if_valid) begin
                    m_v = 1'b1; m_pc = if_pc; m_inst = if_inst;
                    pushing = 1'b0;
                end
`endif
                else begin
                    m_v = 1'b0; m_pc = '0; m_inst = '0;
                end
            end
            if (pushing) m_q.push_back({if_pc, if_inst});
        end
    endtask

    // Apply inputs, check the combinational ready, clock once, then compare against the model.
    task automatic step(input logic a_rst, input logic a_flush, input logic a_stall2,
                        input logic a_valid, input logic [31:0] a_pc, input logic [31:0] a_inst);
        rst      = a_rst;
        flush    = a_flush;
        stall    = {3'($urandom), a_stall2, 2'($urandom)};
        if_valid = a_valid;
        if_pc    = a_pc;
        if_inst  = a_inst;
        #1;
        check("if_ready_pre", 64'(if_ready), 64'(m_q.size() < DEPTH));
        @(posedge clk);
        model_update();
        #1;
        check("count",    64'(count),    64'(m_q.size()));
        check("id_valid", 64'(id_valid), 64'(m_v));
        check("id_pc",    64'(id_pc),    64'(m_pc));
        check("id_inst",  64'(id_inst),  64'(m_inst));
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; stall = '0; if_valid = 1'b0; if_pc = '0; if_inst = '0;

        // Reset held two cycles with fetch active
        step(1, 0, 0, 1, 32'h0000_0050, inst_of(32'h50));
        step(1, 0, 0, 1, 32'h0000_0054, inst_of(32'h54));
        check("rst_count",    64'(count),    64'd0);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_id_pc",    64'(id_pc),    64'd0);
        check("rst_if_ready", 64'(if_ready), 64'd1);

        // Fill while decode stalls; fifth push dropped
        for (int n = 0; n < 4; n++) step(0, 0, 1, 1, 32'h100 + 32'(4 * n), inst_of(32'h100 + 32'(4 * n)));
        check("fill_count", 64'(count), 64'd4);
        rst = 1'b0; flush = 1'b0; stall = 6'b000100; if_valid = 1'b1; if_pc = 32'h110;
        #1;
        check("fill_if_ready_full", 64'(if_ready), 64'd0);
        step(0, 0, 1, 1, 32'h110, inst_of(32'h110));
        check("fill_count_hold", 64'(count), 64'd4);
        for (int n = 0; n < 4; n++) begin
            step(0, 0, 0, 0, 32'h0, 32'h0);
            check("drain_pc",    64'(id_pc),    64'(32'h100 + 32'(4 * n)));
            check("drain_valid", 64'(id_valid), 64'd1);
        end
        step(0, 0, 0, 0, 32'h0, 32'h0);
        check("drain_bubble", 64'(id_valid), 64'd0);

        // Continuous push/pop across pointer wrap
        for (int n = 0; n < 10; n++) step(0, 0, 0, 1, 32'h200 + 32'(4 * n), inst_of(32'h200 + 32'(4 * n)));
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Flush with three queued and fetch presenting 0x300
        for (int n = 0; n < 3; n++) step(0, 0, 1, 1, 32'h280 + 32'(4 * n), inst_of(32'h280 + 32'(4 * n)));
        check("pre_flush_count", 64'(count), 64'd3);
        step(0, 1, 1, 1, 32'h300, inst_of(32'h300));
        check("flush_count", 64'(count),    64'd0);
        check("flush_valid", 64'(id_valid), 64'd0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        check("flush_not_stored", 64'(id_valid), 64'd0);

        // Push into an empty queue while decode advances
        step(0, 0, 0, 1, 32'h400, inst_of(32'h400));
`ifdef IFQ_BYPASS_EN
        check("empty_push_pc",    64'(id_pc),    64'h400);
        check("empty_push_valid", 64'(id_valid), 64'd1);
        check("empty_push_count", 64'(count),    64'd0);
`else
        check("empty_push_bubble", 64'(id_valid), 64'd0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        check("empty_push_pc",    64'(id_pc),    64'h400);
        check("empty_push_valid", 64'(id_valid), 64'd1);
`endif

        // Reset in the middle of operation
        step(0, 0, 1, 1, 32'h500, inst_of(32'h500));
        step(0, 0, 1, 1, 32'h504, inst_of(32'h504));
        check("midop_pre_count", 64'(count), 64'd2);
        step(1, 0, 1, 1, 32'h508, inst_of(32'h508));
        check("midop_count",    64'(count),    64'd0);
        check("midop_valid",    64'(id_valid), 64'd0);
        check("midop_pc",       64'(id_pc),    64'd0);
        check("midop_inst",     64'(id_inst),  64'd0);
        check("midop_if_ready", 64'(if_ready), 64'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [31:0] pc;
            r  = int'($urandom_range(0, 99));
            pc = {$urandom} & 32'hFFFF_FFFC;
            step(r < 2, (r >= 2) && (r < 6), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0, pc, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
